// File: rtl/pooling_pkg.sv
// Shared types and the pooling operator for the 2x2 pooling stream.
// Provides pool_mode_e, pool_row_e, a wide accumulator type and pool_op.
package pooling_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic {
    ROW0 = 1'b0,
    ROW1 = 1'b1
  } pool_row_e;

  // Wide enough for any practical PIX_W+2; callers truncate.
  localparam int ACC_W = 32;

  typedef logic [ACC_W-1:0] acc_t;

  // Max: unsigned compare. Avg: running sum, divided later.
  function automatic acc_t pool_op(
    input acc_t       a,
    input acc_t       b,
    input pool_mode_e m
  );
    acc_t r;
    if (m == POOL_AVG) begin
      r = a + b;
    end else begin
      r = (a > b) ? a : b;
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Line buffer holding one partial result per output column pair.
// Ports: clk, rst_n, we/widx/wdata write port, ridx/rdata async read.
module pool_linebuf
  import pooling_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 10,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [W-1:0]     rdata
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [DEPTH-1:0][W-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[widx] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/pooling_stream_2x2.sv
// Streaming 2x2 max/avg pooling over raster input, one row pair per vector.
// Ports: clk, rst_n, En, sof, mode, convResult in; pooledPixels, outValid, busy out.
module pooling_stream_2x2
  import pooling_pkg::*;
#(
  parameter  int PIX_W   = 8,
  parameter  int ROW_LEN = 8,
  localparam int OUT_N   = ROW_LEN / 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        En,
  input  logic                        sof,
  input  logic                        mode,
  input  logic [PIX_W-1:0]            convResult,
  output logic [OUT_N-1:0][PIX_W-1:0] pooledPixels,
  output logic                        outValid,
  output logic                        busy
);

  localparam int SUM_W = PIX_W + 2;
  localparam int CW    = $clog2(ROW_LEN);
  localparam int IDX_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  pool_row_e                   state_q, state_d;
  logic [CW-1:0]               col_q, col_d;
  logic [PIX_W-1:0]            pair_q, pair_d;
  pool_mode_e                  mode_q, mode_d;
  logic [OUT_N-1:0][PIX_W-1:0] res_q, res_d;
  logic [OUT_N-1:0][PIX_W-1:0] pooled_q, pooled_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;

  pool_row_e       row_eff;
  logic [CW-1:0]   col_eff;
  pool_mode_e      mode_eff;
  logic [IDX_W-1:0] idx;
  logic            last_col;
  logic [SUM_W-1:0] h_sum;
  logic [SUM_W-1:0] v_sum;
  logic [SUM_W-1:0] lb_rdata;
  logic            lb_we;
  logic [PIX_W-1:0] pool_val;

  pool_linebuf #(
    .DEPTH (OUT_N),
    .W     (SUM_W),
    .IDX_W (IDX_W)
  ) u_linebuf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lb_we),
    .widx  (idx),
    .wdata (h_sum),
    .ridx  (idx),
    .rdata (lb_rdata)
  );

  // sof re-positions this sample to the start of a fresh pair.
  always_comb begin
    row_eff  = sof ? ROW0 : state_q;
    col_eff  = sof ? '0 : col_q;
    // Mode is taken live only on the first sample of a pair.
    if (row_eff == ROW0 && col_eff == '0) begin
      mode_eff = pool_mode_e'(mode);
    end else begin
      mode_eff = mode_q;
    end
    idx      = IDX_W'(col_eff >> 1);
    last_col = (col_eff == CW'(ROW_LEN - 1));
    h_sum    = SUM_W'(pool_op(acc_t'(pair_q),
                              acc_t'(convResult),
                              mode_eff));
    v_sum    = SUM_W'(pool_op(acc_t'(lb_rdata),
                              acc_t'(h_sum),
                              mode_eff));
    if (mode_eff == POOL_AVG) begin
      pool_val = PIX_W'(v_sum >> 2);
    end else begin
      pool_val = PIX_W'(v_sum);
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    pair_d   = pair_q;
    mode_d   = mode_q;
    res_d    = res_q;
    pooled_d = pooled_q;
    valid_d  = 1'b0;
    lb_we    = 1'b0;
    if (En) begin
      mode_d = mode_eff;
      if (!col_eff[0]) begin
        pair_d = convResult;
      end else if (row_eff == ROW0) begin
        lb_we = 1'b1;
      end else begin
        res_d[idx] = pool_val;
      end
      if (last_col) begin
        col_d   = '0;
        state_d = (row_eff == ROW0) ? ROW1 : ROW0;
        // Publish the whole row at once so the output never tears.
        if (row_eff == ROW1) begin
          pooled_d = res_d;
          valid_d  = 1'b1;
        end
      end else begin
        col_d   = col_eff + CW'(1);
        state_d = row_eff;
      end
    end
    busy_d = (state_d == ROW1) || (col_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ROW0;
      col_q    <= '0;
      pair_q   <= '0;
      mode_q   <= POOL_MAX;
      res_q    <= '0;
      pooled_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      pair_q   <= pair_d;
      mode_q   <= mode_d;
      res_q    <= res_d;
      pooled_q <= pooled_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign pooledPixels = pooled_q;
  assign outValid     = valid_q;
  assign busy         = busy_q;

endmodule
